// File: rtl/ext_pkg.sv
// Shared constants for the immediate-extension arbiter.
// Op field encodings and their ImmSrc selects for the extend unit.
package ext_pkg;

  localparam logic [1:0] IMM_DP8   = 2'b00;
  localparam logic [1:0] IMM_MEM12 = 2'b01;
  localparam logic [1:0] IMM_BR24  = 2'b10;
  localparam logic [1:0] IMM_NONE  = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  function automatic logic [1:0] op_to_immsrc(input logic [1:0] op);
    logic [1:0] src;
    case (op)
      OP_DP:   src = IMM_DP8;
      OP_MEM:  src = IMM_MEM12;
      OP_BR:   src = IMM_BR24;
      default: src = IMM_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/ext_extend.sv
// Immediate extension unit (DP8 / MEM12 / BR24).
// EXT_ROT_EN: DP8 becomes the rotated 8-bit immediate.
module ext_extend
  import ext_pkg::*;
(
  input  logic [23:0] instr_i,
  input  logic [1:0]  immsrc_i,
  output logic [31:0] imm_o
);

  logic [31:0] zx8;
  logic [31:0] dp8;

  assign zx8 = {24'b0, instr_i[7:0]};

`ifdef EXT_ROT_EN
  logic [4:0] rot;
  assign rot = {instr_i[11:8], 1'b0};
  // a left shift of 32 yields zero, so rot==0 is just zx8
  assign dp8 = (zx8 >> rot) | (zx8 << (6'd32 - {1'b0, rot}));
`else
  assign dp8 = zx8;
`endif

  always_comb begin
    imm_o = '0;
    case (immsrc_i)
      IMM_DP8:   imm_o = dp8;
      IMM_MEM12: imm_o = {20'b0, instr_i[11:0]};
      IMM_BR24:  imm_o = {{6{instr_i[23]}}, instr_i, 2'b00};
      default:   imm_o = '0;
    endcase
  end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester arbiter in front of the extend unit, one-entry output slot.
// Build option EXT_ROT_EN selects rotated DP8 immediates in ext_extend.
module ext_arbiter
  import ext_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_instr,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_instr,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_imm,
  output logic        resp_id,
  output logic        resp_err
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic             valid_q, valid_d;
  logic [31:0]      imm_q, imm_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] burst_q, burst_d;

  logic        slot_free;
  logic        gnt0, gnt1;
  logic [23:0] sel_instr;
  logic [1:0]  sel_op;
  logic [31:0] ext_imm;

  assign slot_free = !valid_q | resp_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !flush && slot_free) begin
      if (req1_valid && (!req0_valid || burst_q == BURST_MAX)) gnt1 = 1'b1;
      else if (req0_valid) gnt0 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_instr = gnt1 ? req1_instr : req0_instr;
  assign sel_op    = gnt1 ? req1_op : req0_op;

  ext_extend u_ext (
    .instr_i  (sel_instr),
    .immsrc_i (op_to_immsrc(sel_op)),
    .imm_o    (ext_imm)
  );

  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    id_d    = id_q;
    err_d   = err_q;
    burst_d = burst_q;
    if (flush) begin
      valid_d = 1'b0;
      burst_d = '0;
    end else if (gnt0 || gnt1) begin
      valid_d = 1'b1;
      id_d    = gnt1;
      err_d   = (sel_op == OP_BAD);
      imm_d   = (sel_op == OP_BAD) ? 32'h0 : ext_imm;
      // starvation guard only counts req0 wins while req1 is waiting
      if (gnt1 || !req1_valid) burst_d = '0;
      else if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
    end else if (resp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      burst_q <= '0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      id_q    <= id_d;
      err_q   <= err_d;
      burst_q <= burst_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_imm   = imm_q;
  assign resp_id    = id_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed + random bench for ext_arbiter with a transaction-level model.
// Build with EXT_ROT_EN to exercise rotated DP8 immediates.
module tb_ext_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req0_valid, req1_valid, resp_ready;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_instr, req1_instr;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_id, resp_err;
  logic [31:0] resp_imm;

  int vectors = 0;
  int miscompares = 0;

  bit          m_valid, m_id, m_err, m_chk;
  logic [31:0] m_imm;
  int          streak;
  bit          g0, g1;
  int          seq[$];
  logic [31:0] held;

  ext_arbiter #(.MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_instr (req0_instr),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_instr (req1_instr),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_imm   (resp_imm),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_imm(logic [23:0] ins, logic [1:0] op);
    int s;
    logic [63:0] d;
    case (op)
      2'd0: begin
`ifdef EXT_ROT_EN
        d = {2{32'(ins[7:0])}};
        d = d >> (2 * int'(ins[11:8]));
        return d[31:0];
`else
        d = 64'(ins) & 64'hFF;
        return d[31:0];
`endif
      end
      2'd1: return 32'(ins) & 32'hFFF;
      2'd2: begin
        s = int'(ins);
        if (s >= 2 ** 23) s = s - 2 ** 24;
        return 32'(s * 4);
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v0, logic [23:0] i0, logic [1:0] o0,
                       bit v1, logic [23:0] i1, logic [1:0] o1);
    req0_valid = v0; req0_instr = i0; req0_op = o0;
    req1_valid = v1; req1_instr = i1; req1_op = o1;
  endtask

  // one clock: check readies, advance model at the edge, check the slot
  task automatic cyc();
    logic [1:0]  op;
    logic [23:0] ins;
    #1;
    g0 = 0;
    g1 = 0;
    if (!reset && !flush && (!m_valid || resp_ready)) begin
      if (req1_valid && (!req0_valid || streak >= MB)) g1 = 1;
      else if (req0_valid) g0 = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_imm = 0; m_id = 0; m_err = 0; streak = 0; m_chk = 1;
    end else if (flush) begin
      m_valid = 0; streak = 0; m_chk = 0;
    end else if (g0 || g1) begin
      op  = g1 ? req1_op : req0_op;
      ins = g1 ? req1_instr : req0_instr;
      m_valid = 1; m_chk = 1; m_id = g1;
      m_err = (op == 2'b11);
      m_imm = ref_imm(ins, op);
      if (g1 || !req1_valid) streak = 0;
      else if (streak < MB) streak++;
    end else if (resp_ready) begin
      m_valid = 0; m_chk = 0;
    end
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    if (m_chk) begin
      chk("resp_imm", resp_imm, m_imm);
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("resp_err", 32'(resp_err), 32'(m_err));
    end
  endtask

  initial begin
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_fl[5] = '{0, 0, 0, 0, 1};
    reset = 1; flush = 0; resp_ready = 1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_imm", resp_imm, 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset = 0;

    drive(1, 24'h000ABC, 2'b01, 0, 0, 0);
    cyc();
    chk("zx12_gnt", 32'(g0), 32'd1);
    chk("zx12_imm", resp_imm, 32'h00000ABC);
    chk("zx12_id", 32'(resp_id), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    cyc();

    drive(0, 0, 0, 1, 24'h800001, 2'b10);
    cyc();
    chk("br_imm", resp_imm, 32'hFE000004);
    chk("br_id", 32'(resp_id), 32'd1);

    drive(1, 24'h000123, 2'b01, 1, 24'h000456, 2'b00);
    seq.delete();
    repeat (10) begin
      cyc();
      seq.push_back(int'(g1));
    end
    for (int i = 0; i < 10; i++) chk("starve_seq", 32'(seq[i]), 32'(exp_seq[i]));

    cyc();
    cyc();
    resp_ready = 0;
    held = resp_imm;
    repeat (3) begin
      cyc();
      chk("bp_hold_imm", resp_imm, held);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
    end
    flush = 1;
    resp_ready = 1;
    cyc();
    chk("flush_valid", 32'(resp_valid), 32'd0);
    flush = 0;
    seq.delete();
    repeat (5) begin
      cyc();
      seq.push_back(int'(g1));
    end
    for (int i = 0; i < 5; i++) chk("flush_burst", 32'(seq[i]), 32'(exp_fl[i]));

    drive(1, 24'hFFFFFF, 2'b11, 0, 0, 0);
    cyc();
    chk("bad_err", 32'(resp_err), 32'd1);
    chk("bad_imm", resp_imm, 32'h0);
    drive(1, 24'h7FFFFF, 2'b10, 0, 0, 0);
    cyc();
    reset = 1;
    cyc();
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_imm", resp_imm, 32'd0);
    reset = 0;

    drive(1, 24'h0001FF, 2'b00, 0, 0, 0);
    cyc();
`ifdef EXT_ROT_EN
    chk("dp8_imm", resp_imm, 32'hC000003F);
`else
    chk("dp8_imm", resp_imm, 32'h000000FF);
`endif

    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && !g0)) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_instr = 24'($urandom);
        req0_op    = 2'($urandom);
      end
      if (!(req1_valid && !g1)) begin
        req1_valid = ($urandom_range(0, 1) != 0);
        req1_instr = 24'($urandom);
        req1_op    = 2'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
